data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder (slave end) of the `ReadIF`/`WriteIF` data buses driven by the execute stage's load/store unit. Holds a word-organised synchronous RAM, accepts single-beat read and write requests, applies byte strobes, and returns read data after a fixed programmable latency. Sits beside the core on the data-bus side, opposite the execute stage.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096, RAM size in 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0001_0000, byte address of word 0; aligned to `4*DEPTH_WORDS`.
- `READ_LATENCY`, 1, cycles from read acceptance to response; 1..8.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r_bus`  `ReadIF.Slave`  –  `req` (1, in), `addr` (32, in), `busy` (1, out), `valid` (1, out), `data` (32, out).
- `w_bus`  `WriteIF.Slave`  –  `req` (1, in), `addr` (32, in), `data` (32, in), `strb` (4, in), `busy` (1, out), `done` (1, out).
- `access_fault`  out  1  one-cycle pulse on an out-of-range access (see Configuration).

## Operation
- Requests are single-cycle pulses; the master issues `req` only while the matching `busy` is low. A `req` seen while `busy` is high is ignored.
- `addr[1:0]` are ignored; all accesses are word-wide. Read returns the full word; lane selection and sign extension stay in the master.
- Word index = `(addr - BASE_ADDR) >> 2`, truncated to `$clog2(DEPTH_WORDS)` bits.
- FSM states:
  - `IDLE`: r_req → load latency counter with `READ_LATENCY`, latch index, go `READ`. w_req → write, go `WACK`. Both → write, latch read into pending register, go `WACK`.
  - `READ`: counter decrements; at 1 drive the response and return to `IDLE`.
  - `WACK`: pulse `w_bus.done`. If a read is pending, go `READ` with the counter loaded; else go `IDLE`.
- Write: lanes with `strb[i]=1` update byte i at the accept edge; `strb=4'b0000` is a legal no-op that still completes.
- Read-after-write to the same word, including the simultaneous case, returns the post-write data.
- `r_bus.busy` is high in `READ`, and in `WACK` while a read is pending. `w_bus.busy` is high in `READ` and `WACK`. Both are registered.
- RAM contents are not reset.
- Reset values: `r_bus.busy`=0, `r_bus.valid`=0, `r_bus.data`=0, `w_bus.busy`=0, `w_bus.done`=0, `access_fault`=0. FSM goes to `IDLE`, pending read clears.
- Reset mid-operation: the in-flight or pending read is discarded, and no `valid` or `done` is issued afterwards. A write already committed before the reset stays in the RAM.

## Timing
- Read accepted at edge N:
  - `r_bus.busy` is high for cycles N+1 … N+READ_LATENCY.
  - `r_bus.valid` and `r_bus.data` are valid for exactly the cycle N+READ_LATENCY.
  - `r_bus.data` holds its value after the response; `valid` drops.
- Write accepted at edge N: RAM updated at N. `w_bus.done` and `w_bus.busy` are high for cycle N+1 only.
- Simultaneous read and write accepted at edge N: `done` in cycle N+1, read response in cycle N+1+READ_LATENCY.
- Back-to-back throughput:
  - Reads: one per READ_LATENCY+1 cycles.
  - Writes: one every 2 cycles.

## Configuration
- `DATA_MEM_RANGE_CHECK_EN` defined: an access with address outside `[BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)` gets a normal handshake and timing, but:
  - An out-of-range write leaves the RAM unchanged.
  - An out-of-range read returns 32'h0.
  - `access_fault` pulses high in the response cycle: the `valid` cycle for reads, the `done` cycle for writes.
- Not defined: no range compare; the index wraps modulo `DEPTH_WORDS`, and `access_fault` is tied 0.

## Test plan
- Reset, then read 0x0001_0000 with READ_LATENCY=1 → `valid` for 1 cycle at N+1; `busy` is 0 at N+2.
- Write 0x0001_0010, data 32'hDEADBEEF, strb 4'b1111, then write 32'h000000AA with strb 4'b0001, then read → returns 32'hDEADBEAA; `done` is exactly 1 cycle per write.
- Read and write to 0x0001_0020 in the same cycle, wdata 32'h12345678, READ_LATENCY=3 → `done` at N+1, `valid` with 32'h12345678 at N+4, `r_bus.busy` high N+1..N+3.
- With the range check built in, read 0x0000_0000 → `valid`, data 0, `access_fault` high in the same cycle. Write 0x0002_0000 → RAM unchanged, `access_fault` high with `done`. Without it → `access_fault` stays 0 and the access wraps.
- READ_LATENCY=4: accept a read, assert `rst` at N+2 for 1 cycle → no `valid` ever, all outputs 0. A new read after reset completes normally.
- `r_bus.req` pulsed while `busy` is high → ignored; exactly one `valid` per accepted request.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-bus interfaces between the load/store unit (master)
// and the data-memory responder (slave).
interface ReadIF;
  logic        req;
  logic [31:0] addr;
  logic        busy;
  logic        valid;
  logic [31:0] data;

  modport Master (
    output req, addr,
    input  busy, valid, data
  );
  modport Slave (
    input  req, addr,
    output busy, valid, data
  );
endinterface

interface WriteIF;
  logic        req;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        busy;
  logic        done;

  modport Master (
    output req, addr, data, strb,
    input  busy, done
  );
  modport Slave (
    input  req, addr, data, strb,
    output busy, done
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM slave for the ReadIF/WriteIF buses.
// Define DATA_MEM_RANGE_CHECK_EN to fault out-of-range accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  ReadIF.Slave  r_bus,
  WriteIF.Slave w_bus,
  output logic access_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(READ_LATENCY);
`ifdef DATA_MEM_RANGE_CHECK_EN
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WACK
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic            rd_oor_q, rd_oor_d;
  logic            pend_q, pend_d;
  logic            r_busy_q, r_busy_d;
  logic            r_valid_q, r_valid_d;
  logic [31:0]     r_data_q, r_data_d;
  logic            w_busy_q, w_busy_d;
  logic            w_done_q, w_done_d;
  logic            fault_q, fault_d;

  logic [31:0]   r_off, w_off;
  logic [AW-1:0] r_idx, w_idx;
  logic          r_oor, w_oor;
  logic          r_acc, w_acc, we;
  logic          unused_bits;

  assign r_off = r_bus.addr - BASE_ADDR;
  assign w_off = w_bus.addr - BASE_ADDR;
  assign r_idx = r_off[AW+1:2];
  assign w_idx = w_off[AW+1:2];
  assign unused_bits = ^{r_off, w_off};

`ifdef DATA_MEM_RANGE_CHECK_EN
  // Addresses below BASE_ADDR wrap to huge offsets.
  assign r_oor = (r_off >= SPAN);
  assign w_oor = (w_off >= SPAN);
`else
  assign r_oor = 1'b0;
  assign w_oor = 1'b0;
`endif

  assign r_acc = (state_q == IDLE) && r_bus.req;
  assign w_acc = (state_q == IDLE) && w_bus.req;
  assign we    = w_acc && !w_oor && !rst;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_bus.strb[i]) begin
          mem[w_idx][8*i +: 8] <= w_bus.data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    rd_oor_d = rd_oor_q;
    pend_d   = pend_q;
    r_data_d = r_data_q;
    fault_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (r_acc) begin
          rd_idx_d = r_idx;
          rd_oor_d = r_oor;
        end
        if (w_acc) begin
          state_d = WACK;
          fault_d = w_oor;
          pend_d  = r_acc;
        end else if (r_acc) begin
          state_d = READ;
          cnt_d   = LAT;
        end
      end
      READ: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      WACK: begin
        if (pend_q) begin
          state_d = READ;
          cnt_d   = LAT;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read is sampled at the edge entering the response cycle,
    // so a simultaneous write is already committed.
    r_valid_d = (state_d == READ) && (cnt_d == 4'd1);
    if (r_valid_d) begin
      r_data_d = rd_oor_d ? 32'h0 : mem[rd_idx_d];
      fault_d  = rd_oor_d;
    end

    r_busy_d = (state_d == READ) || ((state_d == WACK) && pend_d);
    w_busy_d = (state_d != IDLE);
    w_done_d = (state_d == WACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_idx_q  <= '0;
      rd_oor_q  <= 1'b0;
      pend_q    <= 1'b0;
      r_busy_q  <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      w_busy_q  <= 1'b0;
      w_done_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_idx_q  <= rd_idx_d;
      rd_oor_q  <= rd_oor_d;
      pend_q    <= pend_d;
      r_busy_q  <= r_busy_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      w_busy_q  <= w_busy_d;
      w_done_q  <= w_done_d;
      fault_q   <= fault_d;
    end
  end

  assign r_bus.busy   = r_busy_q;
  assign r_bus.valid  = r_valid_q;
  assign r_bus.data   = r_data_q;
  assign w_bus.busy   = w_busy_q;
  assign w_bus.done   = w_done_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at latencies 1, 3 and 4.
// Optional range-check expectations follow DATA_MEM_RANGE_CHECK_EN.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  logic f1, f3, f4;
  int   n_cmp = 0;
  int   n_err = 0;
  int   nv;

  always #5 clk = ~clk;

  ReadIF  r1 ();
  ReadIF  r3 ();
  ReadIF  r4 ();
  WriteIF w1 ();
  WriteIF w3 ();
  WriteIF w4 ();

  data_mem_responder #(.READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .r_bus(r1), .w_bus(w1),
    .access_fault(f1)
  );
  data_mem_responder #(.READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .r_bus(r3), .w_bus(w3),
    .access_fault(f3)
  );
  data_mem_responder #(.READ_LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .r_bus(r4), .w_bus(w4),
    .access_fault(f4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic u1_write(logic [31:0] a, logic [31:0] d,
                          logic [3:0] s, logic ef);
    w1.req = 1'b1; w1.addr = a; w1.data = d; w1.strb = s;
    tick();
    w1.req = 1'b0;
    chk("w1_done", 32'(w1.done), 32'd1);
    chk("w1_busy", 32'(w1.busy), 32'd1);
    chk("w1_rbusy", 32'(r1.busy), 32'd0);
    chk("w1_fault", 32'(f1), 32'(ef));
    tick();
    chk("w1_done_drop", 32'(w1.done), 32'd0);
    chk("w1_busy_drop", 32'(w1.busy), 32'd0);
  endtask

  task automatic u1_read(logic [31:0] a, logic [31:0] ed,
                         logic ef);
    r1.req = 1'b1; r1.addr = a;
    tick();
    r1.req = 1'b0;
    chk("r1_valid", 32'(r1.valid), 32'd1);
    chk("r1_data", r1.data, ed);
    chk("r1_busy", 32'(r1.busy), 32'd1);
    chk("r1_fault", 32'(f1), 32'(ef));
    tick();
    chk("r1_valid_drop", 32'(r1.valid), 32'd0);
    chk("r1_busy_drop", 32'(r1.busy), 32'd0);
    chk("r1_data_hold", r1.data, ed);
    chk("r1_fault_drop", 32'(f1), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    r1.req = 0; r1.addr = 0;
    r3.req = 0; r3.addr = 0;
    r4.req = 0; r4.addr = 0;
    w1.req = 0; w1.addr = 0; w1.data = 0; w1.strb = 0;
    w3.req = 0; w3.addr = 0; w3.data = 0; w3.strb = 0;
    w4.req = 0; w4.addr = 0; w4.data = 0; w4.strb = 0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_rbusy", 32'(r1.busy), 32'd0);
    chk("rst_valid", 32'(r1.valid), 32'd0);
    chk("rst_rdata", r1.data, 32'd0);
    chk("rst_wbusy", 32'(w1.busy), 32'd0);
    chk("rst_done", 32'(w1.done), 32'd0);
    chk("rst_fault", 32'(f1), 32'd0);

    u1_write(32'h0001_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
    u1_read(32'h0001_0000, 32'hCAFE_F00D, 1'b0);

    u1_write(32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    u1_write(32'h0001_0010, 32'h0000_00AA, 4'h1, 1'b0);
    u1_read(32'h0001_0010, 32'hDEAD_BEAA, 1'b0);
    u1_write(32'h0001_0010, 32'hFFFF_FFFF, 4'h0, 1'b0);
    u1_read(32'h0001_0010, 32'hDEAD_BEAA, 1'b0);
    u1_write(32'h0001_0012, 32'h1100_2200, 4'hA, 1'b0);
    u1_read(32'h0001_0011, 32'h11AD_22AA, 1'b0);

    // simultaneous read+write, latency 3
    r3.req = 1; r3.addr = 32'h0001_0020;
    w3.req = 1; w3.addr = 32'h0001_0020;
    w3.data = 32'h1234_5678; w3.strb = 4'hF;
    tick();
    r3.req = 0; w3.req = 0;
    chk("sim_done_n1", 32'(w3.done), 32'd1);
    chk("sim_rbusy_n1", 32'(r3.busy), 32'd1);
    chk("sim_valid_n1", 32'(r3.valid), 32'd0);
    tick();
    chk("sim_done_n2", 32'(w3.done), 32'd0);
    chk("sim_rbusy_n2", 32'(r3.busy), 32'd1);
    chk("sim_valid_n2", 32'(r3.valid), 32'd0);
    tick();
    chk("sim_rbusy_n3", 32'(r3.busy), 32'd1);
    chk("sim_valid_n3", 32'(r3.valid), 32'd0);
    tick();
    chk("sim_valid_n4", 32'(r3.valid), 32'd1);
    chk("sim_data_n4", r3.data, 32'h1234_5678);
    tick();
    chk("sim_valid_n5", 32'(r3.valid), 32'd0);
    chk("sim_rbusy_n5", 32'(r3.busy), 32'd0);

    // request while busy is ignored
    r3.req = 1; r3.addr = 32'h0001_0020;
    tick();
    r3.req = 0;
    tick();
    chk("ign_busy", 32'(r3.busy), 32'd1);
    r3.req = 1; r3.addr = 32'h0001_0000;
    tick();
    r3.req = 0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (r3.valid) begin
        nv++;
        chk("ign_data", r3.data, 32'h1234_5678);
      end
      tick();
    end
    chk("ign_nvalid", 32'(nv), 32'd1);
    chk("ign_idle", 32'(r3.busy), 32'd0);

`ifdef DATA_MEM_RANGE_CHECK_EN
    u1_write(32'h0002_0000, 32'h55AA_55AA, 4'hF, 1'b1);
    u1_read(32'h0000_0000, 32'h0, 1'b1);
    u1_read(32'h0001_0000, 32'hCAFE_F00D, 1'b0);
`else
    u1_write(32'h0002_0000, 32'h55AA_55AA, 4'hF, 1'b0);
    u1_read(32'h0000_0000, 32'h55AA_55AA, 1'b0);
    u1_read(32'h0001_0000, 32'h55AA_55AA, 1'b0);
`endif

    // reset in the middle of a latency-4 read
    r4.req = 1; r4.addr = 32'h0001_0020;
    tick();
    r4.req = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (r4.valid || w4.done) nv++;
      tick();
    end
    chk("mrst_no_resp", 32'(nv), 32'd0);
    chk("mrst_rbusy", 32'(r4.busy), 32'd0);
    chk("mrst_rdata", r4.data, 32'd0);
    chk("mrst_wbusy", 32'(w4.busy), 32'd0);
    chk("mrst_fault", 32'(f4), 32'd0);
    chk("mrst_keep_ram", 32'(u1.mem[4]), 32'h11AD_22AA);

    w4.req = 1; w4.addr = 32'h0001_0030;
    w4.data = 32'h0A0B_0C0D; w4.strb = 4'hF;
    tick();
    w4.req = 0;
    chk("post_done", 32'(w4.done), 32'd1);
    tick();
    r4.req = 1; r4.addr = 32'h0001_0030;
    tick();
    r4.req = 0;
    tick();
    tick();
    chk("post_valid_n3", 32'(r4.valid), 32'd0);
    tick();
    chk("post_valid_n4", 32'(r4.valid), 32'd1);
    chk("post_data_n4", r4.data, 32'h0A0B_0C0D);
    tick();
    chk("post_valid_n5", 32'(r4.valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
